// File: rtl/sort_frame_ctrl.sv
// sort_frame_ctrl: collects a serial word stream into a padded frame, launches one parallel sort,
// then streams the sorted real words back out. Define SORT_WDOG_EN to enable the WAIT watchdog.

module sort_frame_slot #(
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic          pad_en_i,
  input  logic          cap_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [DW-1:0] pad_i,
  input  logic [DW-1:0] y_i,
  output logic [DW-1:0] x_o,
  output logic [DW-1:0] y_o
);
  logic [DW-1:0] x_q, y_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      if (wr_en_i)       x_q <= wr_data_i;
      else if (pad_en_i) x_q <= pad_i;
      if (cap_en_i)      y_q <= y_i;
    end
  end

  assign x_o = x_q;
  assign y_o = y_q;
endmodule

module sort_frame_ctrl #(
  parameter int LOG_INPUT   = 5,
  parameter int DATA_WIDTH  = 32,
  parameter int ASCENDING   = 1,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  in_valid_i,
  input  logic [DATA_WIDTH-1:0]                 in_data_i,
  input  logic                                  in_last_i,
  output logic                                  in_ready_o,
  output logic [(2**LOG_INPUT)*DATA_WIDTH-1:0]  sort_x_o,
  output logic                                  sort_x_valid_o,
  input  logic [(2**LOG_INPUT)*DATA_WIDTH-1:0]  sort_y_i,
  input  logic                                  sort_y_valid_i,
  output logic                                  out_valid_o,
  output logic [DATA_WIDTH-1:0]                 out_data_o,
  output logic                                  out_last_o,
  input  logic                                  out_ready_i,
  output logic                                  busy_o,
  output logic                                  err_o
);
  localparam int N  = 2**LOG_INPUT;
  localparam int CW = LOG_INPUT + 1;
  // Pad sorts to the tail so the first cnt sorted words are exactly the real data.
  localparam logic [DATA_WIDTH-1:0] PAD = (ASCENDING != 0) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};

  typedef enum logic [1:0] {S_FILL, S_LAUNCH, S_WAIT, S_DRAIN} state_e;

  state_e                             state_q, state_d;
  logic [CW-1:0]                      wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d, cnt_q, cnt_d;
  logic [N-1:0][DATA_WIDTH-1:0]       xbuf, ybuf;
  logic                               acc, fill_done, cap, last_word;

  assign in_ready_o     = rst_i && (state_q == S_FILL);
  assign acc            = in_ready_o && in_valid_i;
  assign fill_done      = acc && (in_last_i || wr_idx_q == CW'(N-1));
  assign cap            = (state_q == S_WAIT) && sort_y_valid_i;
  assign last_word      = (rd_idx_q == cnt_q - CW'(1));

  assign sort_x_o       = xbuf;
  assign sort_x_valid_o = (state_q == S_LAUNCH);
  assign out_valid_o    = (state_q == S_DRAIN);
  assign out_last_o     = (state_q == S_DRAIN) && last_word;
  assign out_data_o     = (state_q == S_DRAIN) ? ybuf[rd_idx_q[LOG_INPUT-1:0]] : '0;
  assign busy_o         = (state_q != S_FILL);

  for (genvar i = 0; i < N; i++) begin : g_slot
    sort_frame_slot #(.DW(DATA_WIDTH)) u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_en_i   (acc && (wr_idx_q == CW'(i))),
      .pad_en_i  (fill_done && (wr_idx_q < CW'(i))),
      .cap_en_i  (cap),
      .wr_data_i (in_data_i),
      .pad_i     (PAD),
      .y_i       (sort_y_i[DATA_WIDTH*i +: DATA_WIDTH]),
      .x_o       (xbuf[i]),
      .y_o       (ybuf[i])
    );
  end

`ifdef SORT_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign err_o       = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_FILL;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    cnt_d    = cnt_q;
`ifdef SORT_WDOG_EN
    wdog_d   = wdog_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_FILL: begin
        if (acc) begin
          wr_idx_d = wr_idx_q + CW'(1);
          if (fill_done) begin
            cnt_d   = wr_idx_q + CW'(1);
            state_d = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef SORT_WDOG_EN
        wdog_d  = '0;
`endif
      end
      S_WAIT: begin
        if (sort_y_valid_i) begin
          state_d = S_DRAIN;
        end
`ifdef SORT_WDOG_EN
        // Timeout drops the frame silently; err stays set until reset.
        else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
          err_d    = 1'b1;
          state_d  = S_FILL;
          wr_idx_d = '0;
          rd_idx_d = '0;
          cnt_d    = '0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end
      S_DRAIN: begin
        if (out_ready_i) begin
          if (last_word) begin
            rd_idx_d = '0;
            wr_idx_d = '0;
            state_d  = S_FILL;
          end else begin
            rd_idx_d = rd_idx_q + CW'(1);
          end
        end
      end
      default: state_d = S_FILL;
    endcase
  end
endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench: unit 0 is an ascending controller, unit 1 descending; the bench plays the sort
// network with hand-sorted response frames.
module tb_sort_frame_ctrl;
  localparam int N  = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid [2], in_last [2], in_ready [2], sort_x_valid [2], sort_y_valid [2];
  logic out_valid [2], out_last [2], out_ready [2], busy [2], err [2];
  logic [DW-1:0]   in_data [2], out_data [2];
  logic [N*DW-1:0] sort_x [2], sort_y [2];
  int npass = 0, ntot = 0;

  always #5 clk = ~clk;

  sort_frame_ctrl #(.LOG_INPUT(5), .DATA_WIDTH(DW), .ASCENDING(1), .WDOG_CYCLES(16)) u_asc (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid[0]), .in_data_i(in_data[0]), .in_last_i(in_last[0]), .in_ready_o(in_ready[0]),
    .sort_x_o(sort_x[0]), .sort_x_valid_o(sort_x_valid[0]),
    .sort_y_i(sort_y[0]), .sort_y_valid_i(sort_y_valid[0]),
    .out_valid_o(out_valid[0]), .out_data_o(out_data[0]), .out_last_o(out_last[0]),
    .out_ready_i(out_ready[0]), .busy_o(busy[0]), .err_o(err[0]));

  sort_frame_ctrl #(.LOG_INPUT(5), .DATA_WIDTH(DW), .ASCENDING(0), .WDOG_CYCLES(16)) u_desc (
    .clk_i(clk), .rst_i(rst_n),
    .in_valid_i(in_valid[1]), .in_data_i(in_data[1]), .in_last_i(in_last[1]), .in_ready_o(in_ready[1]),
    .sort_x_o(sort_x[1]), .sort_x_valid_o(sort_x_valid[1]),
    .sort_y_i(sort_y[1]), .sort_y_valid_i(sort_y_valid[1]),
    .out_valid_o(out_valid[1]), .out_data_o(out_data[1]), .out_last_o(out_last[1]),
    .out_ready_i(out_ready[1]), .busy_o(busy[1]), .err_o(err[1]));

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_word(input int u, input logic [DW-1:0] d, input logic l, input string nm);
    int t = 0;
    in_valid[u] = 1'b1; in_data[u] = d; in_last[u] = l;
    while (in_ready[u] !== 1'b1 && t < 50) begin step(1); t++; end
    ntot++;
    if (t >= 50) $display("FAIL %s in_ready timeout: got %b want 1", nm, in_ready[u]);
    else npass++;
    step(1);
    in_valid[u] = 1'b0; in_last[u] = 1'b0;
  endtask

  task automatic frame_sent(input int u, input logic [DW-1:0] x [N], input string nm);
    int bad;
    ntot++;
    if (sort_x_valid[u] !== 1'b1) $display("FAIL %s launch pulse: got %b want 1", nm, sort_x_valid[u]);
    else npass++;
    ntot++;
    if (in_ready[u] !== 1'b0 || busy[u] !== 1'b1)
      $display("FAIL %s launch ready/busy: got %b/%b want 0/1", nm, in_ready[u], busy[u]);
    else npass++;
    bad = -1;
    for (int i = 0; i < N; i++) if (sort_x[u][i*DW +: DW] !== x[i] && bad < 0) bad = i;
    ntot++;
    if (bad >= 0) $display("FAIL %s sort_x slot %0d: got %h want %h", nm, bad, sort_x[u][bad*DW +: DW], x[bad]);
    else npass++;
    step(1);
    ntot++;
    if (sort_x_valid[u] !== 1'b0) $display("FAIL %s launch width: got %b want 0", nm, sort_x_valid[u]);
    else npass++;
    bad = -1;
    for (int i = 0; i < N; i++) if (sort_x[u][i*DW +: DW] !== x[i] && bad < 0) bad = i;
    ntot++;
    if (bad >= 0) $display("FAIL %s sort_x held slot %0d: got %h want %h", nm, bad, sort_x[u][bad*DW +: DW], x[bad]);
    else npass++;
  endtask

  task automatic respond(input int u, input logic [DW-1:0] y [N], input int dly, input string nm);
    step(dly);
    ntot++;
    if (out_valid[u] !== 1'b0) $display("FAIL %s early out_valid: got %b want 0", nm, out_valid[u]);
    else npass++;
    for (int i = 0; i < N; i++) sort_y[u][i*DW +: DW] = y[i];
    sort_y_valid[u] = 1'b1;
    step(1);
    sort_y_valid[u] = 1'b0;
  endtask

  task automatic drain(input int u, input logic [DW-1:0] e [N], input int n, input bit toggle,
                       input string nm);
    int k = 0, cyc = 0;
    logic [DW-1:0] held = '0;
    bit stalled = 1'b0;
    while (k < n && cyc < 200) begin
      out_ready[u] = toggle ? (cyc % 2 == 0) : 1'b1;
      ntot++;
      if (out_valid[u] !== 1'b1) $display("FAIL %s out_valid word %0d: got %b want 1", nm, k, out_valid[u]);
      else npass++;
      ntot++;
      if (in_ready[u] !== 1'b0) $display("FAIL %s in_ready in drain: got %b want 0", nm, in_ready[u]);
      else npass++;
      if (stalled) begin
        ntot++;
        if (out_data[u] !== held) $display("FAIL %s stall hold word %0d: got %h want %h", nm, k, out_data[u], held);
        else npass++;
      end
      if (out_ready[u]) begin
        ntot++;
        if (out_data[u] !== e[k]) $display("FAIL %s word %0d: got %h want %h", nm, k, out_data[u], e[k]);
        else npass++;
        ntot++;
        if (out_last[u] !== (k == n-1)) $display("FAIL %s last at word %0d: got %b want %b", nm, k, out_last[u], k == n-1);
        else npass++;
        k++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = out_data[u];
      end
      step(1);
      cyc++;
    end
    out_ready[u] = 1'b0;
    ntot++;
    if (k != n) $display("FAIL %s drain count: got %0d want %0d", nm, k, n);
    else npass++;
    ntot++;
    if (out_valid[u] !== 1'b0 || in_ready[u] !== 1'b1 || busy[u] !== 1'b0)
      $display("FAIL %s after drain valid/ready/busy: got %b/%b/%b want 0/1/0", nm, out_valid[u], in_ready[u], busy[u]);
    else npass++;
  endtask

  task automatic test_reset;
    step(2);
    for (int u = 0; u < 2; u++) begin
      ntot++;
      if ({in_ready[u], sort_x_valid[u], out_valid[u], out_last[u], busy[u], err[u]} !== 6'b0)
        $display("FAIL reset u%0d ctl outs: got %b want 000000", u,
                 {in_ready[u], sort_x_valid[u], out_valid[u], out_last[u], busy[u], err[u]});
      else npass++;
      ntot++;
      if (sort_x[u] !== '0 || out_data[u] !== '0)
        $display("FAIL reset u%0d data: got %0d sort_x ones, out_data %h want 0/0", u, $countones(sort_x[u]), out_data[u]);
      else npass++;
    end
    rst_n = 1'b1;
    step(1);
    for (int u = 0; u < 2; u++) begin
      ntot++;
      if (in_ready[u] !== 1'b1 || busy[u] !== 1'b0)
        $display("FAIL reset u%0d release ready/busy: got %b/%b want 1/0", u, in_ready[u], busy[u]);
      else npass++;
    end
  endtask

  task automatic test_full_frame;
    logic [DW-1:0] w [N], y [N];
    for (int i = 0; i < N; i++) begin w[i] = DW'(32 - i); y[i] = DW'(i + 1); end
    for (int i = 0; i < N; i++) send_word(0, w[i], 1'b0, "full");
    frame_sent(0, w, "full");
    respond(0, y, 3, "full");
    drain(0, y, N, 1'b0, "full");
  endtask

  task automatic test_short_frame;
    logic [DW-1:0] d [5] = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd5};
    logic [DW-1:0] s [5] = '{32'd1, 32'd3, 32'd5, 32'd7, 32'd9};
    logic [DW-1:0] x [N], y [N];
    for (int i = 0; i < N; i++) begin x[i] = 32'hFFFF_FFFF; y[i] = 32'hFFFF_FFFF; end
    for (int i = 0; i < 5; i++) begin x[i] = d[i]; y[i] = s[i]; end
    for (int i = 0; i < 5; i++) send_word(0, d[i], i == 4, "short");
    frame_sent(0, x, "short");
    respond(0, y, 2, "short");
    drain(0, y, 5, 1'b0, "short");
  endtask

  task automatic test_descending;
    logic [DW-1:0] d [3] = '{32'h0, 32'hFFFF_FFFF, 32'h2};
    logic [DW-1:0] x [N], y [N];
    for (int i = 0; i < N; i++) begin x[i] = '0; y[i] = '0; end
    for (int i = 0; i < 3; i++) x[i] = d[i];
    y[0] = 32'hFFFF_FFFF; y[1] = 32'h2;
    for (int i = 0; i < 3; i++) send_word(1, d[i], i == 2, "desc");
    frame_sent(1, x, "desc");
    respond(1, y, 1, "desc");
    drain(1, y, 3, 1'b0, "desc");
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] d [4] = '{32'd4, 32'hFFFF_FFFF, 32'd8, 32'd6};
    logic [DW-1:0] x [N], y [N];
    for (int i = 0; i < N; i++) begin x[i] = 32'hFFFF_FFFF; y[i] = 32'hFFFF_FFFF; end
    for (int i = 0; i < 4; i++) x[i] = d[i];
    y[0] = 32'd4; y[1] = 32'd6; y[2] = 32'd8;
    for (int i = 0; i < 4; i++) send_word(0, d[i], i == 3, "bp");
    frame_sent(0, x, "bp");
    respond(0, y, 1, "bp");
    drain(0, y, 4, 1'b1, "bp");
  endtask

  task automatic test_watchdog;
    logic [DW-1:0] x [N], y [N];
    for (int i = 0; i < N; i++) begin x[i] = 32'hFFFF_FFFF; y[i] = 32'hFFFF_FFFF; end
    x[0] = 32'd3; x[1] = 32'd1;
    send_word(0, 32'd3, 1'b0, "wdog");
    send_word(0, 32'd1, 1'b1, "wdog");
    frame_sent(0, x, "wdog");
`ifdef SORT_WDOG_EN
    step(15);
    ntot++;
    if (err[0] !== 1'b0 || busy[0] !== 1'b1) $display("FAIL wdog early err/busy: got %b/%b want 0/1", err[0], busy[0]);
    else npass++;
    step(1);
    ntot++;
    if (err[0] !== 1'b1) $display("FAIL wdog err: got %b want 1", err[0]);
    else npass++;
    ntot++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1)
      $display("FAIL wdog drop valid/ready: got %b/%b want 0/1", out_valid[0], in_ready[0]);
    else npass++;
    x[0] = 32'd2; y[0] = 32'd1; y[1] = 32'd2;
    send_word(0, 32'd2, 1'b0, "wdog2");
    send_word(0, 32'd1, 1'b1, "wdog2");
    frame_sent(0, x, "wdog2");
    respond(0, y, 1, "wdog2");
    drain(0, y, 2, 1'b0, "wdog2");
    ntot++;
    if (err[0] !== 1'b1) $display("FAIL wdog sticky err: got %b want 1", err[0]);
    else npass++;
`else
    step(40);
    ntot++;
    if (err[0] !== 1'b0 || busy[0] !== 1'b1 || out_valid[0] !== 1'b0)
      $display("FAIL long wait err/busy/valid: got %b/%b/%b want 0/1/0", err[0], busy[0], out_valid[0]);
    else npass++;
    y[0] = 32'd1; y[1] = 32'd3;
    respond(0, y, 1, "wait");
    drain(0, y, 2, 1'b0, "wait");
    ntot++;
    if (err[0] !== 1'b0) $display("FAIL err tied: got %b want 0", err[0]);
    else npass++;
`endif
  endtask

  task automatic test_reset_mid_wait;
    logic [DW-1:0] x [N];
    for (int i = 0; i < N; i++) x[i] = 32'hFFFF_FFFF;
    x[0] = 32'd5; x[1] = 32'd6;
    send_word(0, 32'd5, 1'b0, "rstw");
    send_word(0, 32'd6, 1'b1, "rstw");
    frame_sent(0, x, "rstw");
    step(2);
    #2 rst_n = 1'b0;
    #1;
    ntot++;
    if ({in_ready[0], sort_x_valid[0], out_valid[0], out_last[0], busy[0], err[0]} !== 6'b0)
      $display("FAIL rstw ctl outs: got %b want 000000",
               {in_ready[0], sort_x_valid[0], out_valid[0], out_last[0], busy[0], err[0]});
    else npass++;
    ntot++;
    if (sort_x[0] !== '0 || out_data[0] !== '0)
      $display("FAIL rstw data: got %0d sort_x ones, out_data %h want 0/0", $countones(sort_x[0]), out_data[0]);
    else npass++;
    step(1);
    rst_n = 1'b1;
    step(1);
    ntot++;
    if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0)
      $display("FAIL rstw release ready/busy: got %b/%b want 1/0", in_ready[0], busy[0]);
    else npass++;
    sort_y[0] = {N{32'hA5A5_0001}};
    sort_y_valid[0] = 1'b1;
    step(1);
    sort_y_valid[0] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ntot++;
      if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0)
        $display("FAIL rstw stale y valid/busy: got %b/%b want 0/0", out_valid[0], busy[0]);
      else npass++;
      step(1);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; in_last[u] = 1'b0; in_data[u] = '0;
      sort_y[u] = '0; sort_y_valid[u] = 1'b0; out_ready[u] = 1'b0;
    end
    test_reset();
    test_full_frame();
    test_short_frame();
    test_descending();
    test_backpressure();
    test_watchdog();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
